// File: rtl/niu_pkg.sv
// niu_pkg: shared types, widths and helpers for the NIU transmit path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package niu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } niu_arb_state_t;

   localparam int NIU_DATA_W = 64;
   localparam int NIU_KEEP_W = NIU_DATA_W / 8;

   // Saturating increment for counters up to 64 bits wide. Callers
   // zero-extend their counter and pass their own all-ones ceiling, so one
   // function serves every counter width.
   function automatic logic [63:0] niu_sat_inc(input logic [63:0] val,
                                                input logic [63:0] ceil);
      return (val >= ceil) ? val : val + 64'd1;
   endfunction

endpackage

// File: rtl/niu_rr_arbiter.sv
// niu_rr_arbiter: round-robin pick of the first requester at or after rr_ptr.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is taken.
// Ports: req (request vector), rr_ptr (search start), gnt (one-hot grant),
//        gnt_idx (encoded grant), any (at least one request).
module niu_rr_arbiter #(
   parameter int N_CH  = 4,
   parameter int PTR_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N_CH-1:0]  gnt,
   output logic [PTR_W-1:0] gnt_idx,
   output logic             any
);

   logic [N_CH-1:0] masked;
   logic            hit_hi;

   // Requests at or above the pointer get first chance.
   always_comb begin
      masked = '0;
      for (int i = 0; i < N_CH; i++) begin
         masked[i] = req[i] && (i >= int'(rr_ptr));
      end
   end

   // Two passes: masked requests first, then wrap to the full vector.
   // Scanning downward lets the lowest matching index win.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      hit_hi  = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (masked[i]) begin
            gnt     = '0;
            gnt[i]  = 1'b1;
            gnt_idx = PTR_W'(i);
            hit_hi  = 1'b1;
         end
      end
      if (!hit_hi) begin
         for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
               gnt     = '0;
               gnt[i]  = 1'b1;
               gnt_idx = PTR_W'(i);
            end
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/niu_tx_arbiter.sv
// niu_tx_arbiter: frame-granular round-robin merge of N_CH AXI-Stream sources
//   onto the MAC transmit stream, with link-aware drop/hold and statistics.
// Latency: 1-cycle grant, then zero-latency combinational pass-through.
// Backpressure: granted channel's tready follows m_axis_tready (FWD) or is
//   held high (DROP); all other readies are 0; link down with drop_en=0 holds.
// Ports: clk156/reset; s_axis_* (per-channel slices); m_axis_* (to MAC);
//   link_up, drop_en; frame_cnt/drop_cnt (per-channel CNT_W slices);
//   active_ch (last grant), busy (FWD or DROP).
module niu_tx_arbiter
   import niu_pkg::*;
#(
   parameter int  N_CH   = 4,
   parameter int  DATA_W = NIU_DATA_W,
   parameter int  CNT_W  = 32,
   localparam int KEEP_W = DATA_W / 8,
   localparam int CH_W   = $clog2(N_CH)
) (
   input  logic                     clk156,
   input  logic                     reset,
   input  logic [N_CH*DATA_W-1:0]   s_axis_tdata,
   input  logic [N_CH*KEEP_W-1:0]   s_axis_tkeep,
   input  logic [N_CH-1:0]          s_axis_tvalid,
   input  logic [N_CH-1:0]          s_axis_tlast,
   output logic [N_CH-1:0]          s_axis_tready,
   output logic [DATA_W-1:0]        m_axis_tdata,
   output logic [KEEP_W-1:0]        m_axis_tkeep,
   output logic                     m_axis_tvalid,
   output logic                     m_axis_tlast,
   input  logic                     m_axis_tready,
   input  logic                     link_up,
   input  logic                     drop_en,
   output logic [N_CH*CNT_W-1:0]    frame_cnt,
   output logic [N_CH*CNT_W-1:0]    drop_cnt,
   output logic [CH_W-1:0]          active_ch,
   output logic                     busy
);

   localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

   niu_arb_state_t   state, state_nxt;
   logic [CH_W-1:0]  grant_q, rr_ptr, arb_idx;
   logic [N_CH-1:0]  grant_oh_q, arb_gnt;
   logic             arb_any, load, fwd_done, drop_done;

   logic [DATA_W-1:0] sel_data;
   logic [KEEP_W-1:0] sel_keep;
   logic              sel_valid, sel_last;

   logic [CNT_W-1:0]  frame_q [N_CH];
   logic [CNT_W-1:0]  drop_q  [N_CH];

   niu_rr_arbiter #(.N_CH(N_CH), .PTR_W(CH_W)) u_rr (
      .req     (s_axis_tvalid),
      .rr_ptr  (rr_ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   assign sel_data  = s_axis_tdata[grant_q*DATA_W +: DATA_W];
   assign sel_keep  = s_axis_tkeep[grant_q*KEEP_W +: KEEP_W];
   assign sel_valid = s_axis_tvalid[grant_q];
   assign sel_last  = s_axis_tlast[grant_q];

   // Link and drop_en only matter here in IDLE; once a frame is granted it
   // runs to tlast in the mode chosen at grant time.
   always_comb begin
      state_nxt     = state;
      load          = 1'b0;
      fwd_done      = 1'b0;
      drop_done     = 1'b0;
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      unique case (state)
         IDLE: begin
            if (arb_any && (link_up || drop_en)) begin
               load      = 1'b1;
               state_nxt = link_up ? FWD : DROP;
            end
         end
         FWD: begin
            m_axis_tdata  = sel_data;
            m_axis_tkeep  = sel_keep;
            m_axis_tlast  = sel_last;
            m_axis_tvalid = sel_valid;
            s_axis_tready = grant_oh_q & {N_CH{m_axis_tready}};
            if (sel_valid && m_axis_tready && sel_last) begin
               fwd_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         DROP: begin
            s_axis_tready = grant_oh_q;
            if (sel_valid && sel_last) begin
               drop_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk156 or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         grant_q    <= '0;
         grant_oh_q <= '0;
         rr_ptr     <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            grant_q    <= arb_idx;
            grant_oh_q <= arb_gnt;
         end
         if (fwd_done || drop_done) begin
            rr_ptr <= (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk156 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            frame_q[i] <= '0;
            drop_q[i]  <= '0;
         end
      end else begin
         if (fwd_done) begin
            frame_q[grant_q] <= CNT_W'(niu_sat_inc(64'(frame_q[grant_q]), CNT_MAX));
         end
         if (drop_done) begin
            drop_q[grant_q] <= CNT_W'(niu_sat_inc(64'(drop_q[grant_q]), CNT_MAX));
         end
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_cnt
      assign frame_cnt[i*CNT_W +: CNT_W] = frame_q[i];
      assign drop_cnt[i*CNT_W +: CNT_W]  = drop_q[i];
   end

   assign active_ch = grant_q;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_niu_tx_arbiter.sv
// tb_niu_tx_arbiter: randomized frame sources against a frame-level model of
//   the round-robin/drop/hold rules, compared every cycle, plus literal checks.
module tb_niu_tx_arbiter;

   localparam int N_CH    = 4;
   localparam int DATA_W  = 64;
   localparam int KEEP_W  = 8;
   localparam int CNT_W   = 5;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic                   clk156 = 1'b0;
   logic                   reset;
   logic [N_CH*DATA_W-1:0] s_axis_tdata;
   logic [N_CH*KEEP_W-1:0] s_axis_tkeep;
   logic [N_CH-1:0]        s_axis_tvalid;
   logic [N_CH-1:0]        s_axis_tlast;
   logic [N_CH-1:0]        s_axis_tready;
   logic [DATA_W-1:0]      m_axis_tdata;
   logic [KEEP_W-1:0]      m_axis_tkeep;
   logic                   m_axis_tvalid;
   logic                   m_axis_tlast;
   logic                   m_axis_tready;
   logic                   link_up;
   logic                   drop_en;
   logic [N_CH*CNT_W-1:0]  frame_cnt;
   logic [N_CH*CNT_W-1:0]  drop_cnt;
   logic [1:0]             active_ch;
   logic                   busy;

   niu_tx_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk156(clk156), .reset(reset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
      .m_axis_tready(m_axis_tready),
      .link_up(link_up), .drop_en(drop_en),
      .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
      .active_ch(active_ch), .busy(busy)
   );

   always #5 clk156 = ~clk156;

   int vectors = 0;
   int miscompares = 0;

   // Sources: each channel emits `left` frames; beat contents are derived
   // from (channel, sequence, beat, salt) so any beat is recognisable.
   int          left[N_CH], flen[N_CH], bi[N_CH], seq[N_CH], vprob[N_CH];
   int          len_min[N_CH], len_max[N_CH];
   bit          vld[N_CH], pop[N_CH];
   logic [15:0] salt[N_CH];
   logic [7:0]  lkeep[N_CH];
   int          tr_mode = 0;
   bit          rnd_link = 1'b0;

   // Frame-level model: who owns the output, in which mode, and where the
   // round-robin search starts next.
   int m_st, m_g, m_ptr;   // m_st: 0 idle, 1 forwarding, 2 dropping
   int m_fc[N_CH], m_dc[N_CH];

   int gq[$];
   bit prev_busy = 1'b0;
   bit last_mv = 1'b0;
   int mv_seen = 0, rdy_seen = 0;

   function automatic logic [63:0] src_data(input int ch);
      return {8'(ch), 24'(seq[ch]), 16'(bi[ch]), salt[ch]};
   endfunction
   function automatic logic src_last(input int ch);
      return (bi[ch] == flen[ch] - 1);
   endfunction
   function automatic logic [7:0] src_keep(input int ch);
      return src_last(ch) ? lkeep[ch] : 8'hFF;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic new_frame(input int ch);
      flen[ch]  = int'($urandom_range(len_max[ch], len_min[ch]));
      salt[ch]  = 16'($urandom);
      lkeep[ch] = 8'($urandom_range(255, 1));
   endtask

   task automatic load(input int ch, input int n, input int lmin, input int lmax, input int vp);
      left[ch] = n; len_min[ch] = lmin; len_max[ch] = lmax; vprob[ch] = vp;
      bi[ch] = 0;
      new_frame(ch);
   endtask

   task automatic drive();
      for (int ch = 0; ch < N_CH; ch++) begin
         if (!vld[ch] && left[ch] > 0 && int'($urandom_range(99, 0)) < vprob[ch]) vld[ch] = 1'b1;
         s_axis_tvalid[ch]                  = vld[ch];
         s_axis_tdata[ch*DATA_W +: DATA_W]  = src_data(ch);
         s_axis_tkeep[ch*KEEP_W +: KEEP_W]  = src_keep(ch);
         s_axis_tlast[ch]                   = src_last(ch);
      end
      case (tr_mode)
         0: m_axis_tready = 1'b1;
         1: m_axis_tready = ~m_axis_tready;
         default: m_axis_tready = ($urandom_range(3, 0) != 0);
      endcase
      if (rnd_link) begin
         if ($urandom_range(99, 0) < 3) link_up = ~link_up;
         if ($urandom_range(99, 0) < 5) drop_en = ~drop_en;
      end
   endtask

   function automatic int sat(input int v);
      return (v < CNT_MAX) ? v + 1 : v;
   endfunction

   task automatic check();
      logic [N_CH-1:0] er;
      logic            ev, el;
      logic [63:0]     ed;
      logic [7:0]      ek;
      int              c;
      er = '0; ev = 1'b0; el = 1'b0; ed = '0; ek = '0;
      if (m_st == 1) begin
         er[m_g] = m_axis_tready;
         ev = vld[m_g]; ed = src_data(m_g); ek = src_keep(m_g); el = src_last(m_g);
      end else if (m_st == 2) begin
         er[m_g] = 1'b1;
      end
      chk("s_axis_tready", 64'(s_axis_tready), 64'(er));
      chk("m_axis_tvalid", 64'(m_axis_tvalid), 64'(ev));
      chk("m_axis_tdata", m_axis_tdata, ed);
      chk("m_axis_tkeep", 64'(m_axis_tkeep), 64'(ek));
      chk("m_axis_tlast", 64'(m_axis_tlast), 64'(el));
      chk("busy", 64'(busy), 64'(m_st != 0));
      chk("active_ch", 64'(active_ch), 64'(m_g));
      for (int ch = 0; ch < N_CH; ch++) begin
         chk($sformatf("frame_cnt[%0d]", ch), 64'(frame_cnt[ch*CNT_W +: CNT_W]), 64'(m_fc[ch]));
         chk($sformatf("drop_cnt[%0d]", ch), 64'(drop_cnt[ch*CNT_W +: CNT_W]), 64'(m_dc[ch]));
      end
      if (busy && !prev_busy) gq.push_back(int'(active_ch));
      prev_busy = busy;
      last_mv = m_axis_tvalid;
      if (m_axis_tvalid) mv_seen++;
      if (|s_axis_tready) rdy_seen++;
      for (int ch = 0; ch < N_CH; ch++) pop[ch] = vld[ch] && s_axis_tready[ch];
      if (!reset) begin
         case (m_st)
            0: begin
               c = -1;
               for (int k = N_CH - 1; k >= 0; k--)
                  if (vld[(m_ptr + k) % N_CH]) c = (m_ptr + k) % N_CH;
               if (c >= 0 && (link_up || drop_en)) begin
                  m_g = c;
                  m_st = link_up ? 1 : 2;
               end
            end
            1: if (vld[m_g] && m_axis_tready && src_last(m_g)) begin
               m_fc[m_g] = sat(m_fc[m_g]); m_ptr = (m_g + 1) % N_CH; m_st = 0;
            end
            default: if (vld[m_g] && src_last(m_g)) begin
               m_dc[m_g] = sat(m_dc[m_g]); m_ptr = (m_g + 1) % N_CH; m_st = 0;
            end
         endcase
      end
   endtask

   task automatic apply();
      for (int ch = 0; ch < N_CH; ch++) begin
         if (pop[ch]) begin
            vld[ch] = 1'b0;
            bi[ch]++;
            if (bi[ch] == flen[ch]) begin
               bi[ch] = 0; seq[ch]++; left[ch]--;
               new_frame(ch);
            end
         end
         pop[ch] = 1'b0;
      end
   endtask

   task automatic cycle();
      @(negedge clk156);
      check();
      @(posedge clk156);
      #1;
      apply();
      drive();
   endtask

   function automatic bit all_done();
      for (int ch = 0; ch < N_CH; ch++) if (left[ch] != 0 || vld[ch]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain(input string nm, input int bound);
      int n = 0;
      while (!(all_done() && m_st == 0)) begin
         if (n >= bound) begin
            vectors++; miscompares++;
            $display("FAIL %s: still busy after %0d cycles, required completion", nm, n);
            return;
         end
         cycle();
         n++;
      end
      repeat (2) cycle();
   endtask

   function automatic logic [63:0] fc(input int ch);
      return 64'(frame_cnt[ch*CNT_W +: CNT_W]);
   endfunction
   function automatic logic [63:0] dc(input int ch);
      return 64'(drop_cnt[ch*CNT_W +: CNT_W]);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_k, n;
      reset = 1'b0; link_up = 1'b0; drop_en = 1'b0; m_axis_tready = 1'b1;
      s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
      m_st = 0; m_g = 0; m_ptr = 0;
      for (int ch = 0; ch < N_CH; ch++) begin
         m_fc[ch] = 0; m_dc[ch] = 0; seq[ch] = 0; vld[ch] = 1'b0; pop[ch] = 1'b0;
         load(ch, 0, 1, 1, 0);
      end
      drive();
      #1 reset = 1'b1;
      repeat (3) cycle();
      chk("rst_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_mdata", m_axis_tdata, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;

      // Round-robin fairness: four channels, 25 three-beat frames each.
      link_up = 1'b1; drop_en = 1'b0; tr_mode = 0;
      for (int ch = 0; ch < N_CH; ch++) load(ch, 25, 3, 3, 100);
      gq.delete(); mv_seen = 0;
      drive();
      drain("fairness", 1000);
      for (int ch = 0; ch < N_CH; ch++) chk($sformatf("fair_cnt%0d", ch), fc(ch), 64'd25);
      chk("fair_grants", 64'(gq.size()), 64'd100);
      for (int i = 0; i < 8 && i < gq.size(); i++)
         chk($sformatf("fair_order%0d", i), 64'(gq[i]), 64'(i % 4));
      chk("fair_beats", 64'(mv_seen), 64'd300);

      // Backpressure: one 8-beat frame on channel 2 with tready toggling.
      tr_mode = 1;
      load(2, 1, 8, 8, 100);
      drive();
      drain("backpressure", 100);
      chk("bp_cnt2", fc(2), 64'd26);

      // Drop mode: link down, drop_en set, two frames each on channels 1, 3.
      tr_mode = 0; link_up = 1'b0; drop_en = 1'b1; mv_seen = 0;
      load(1, 2, 1, 5, 70);
      load(3, 2, 1, 5, 70);
      drive();
      drain("drop", 300);
      chk("drop_cnt1", dc(1), 64'd2);
      chk("drop_cnt3", dc(3), 64'd2);
      chk("drop_mvalid", 64'(mv_seen), 64'd0);
      chk("drop_fc1", fc(1), 64'd25);

      // Hold: link down, drop_en clear; then link up; then link loss mid-frame.
      drop_en = 1'b0; rdy_seen = 0;
      load(0, 1, 4, 4, 100);
      drive();
      repeat (20) cycle();
      chk("hold_ready", 64'(rdy_seen), 64'd0);
      link_up = 1'b1;
      first_k = 0;
      for (int k = 1; k <= 10; k++) begin
         cycle();
         if (first_k == 0 && last_mv) first_k = k;
      end
      chk("link_latency", 64'(first_k), 64'd2);
      drain("hold", 100);
      load(0, 1, 6, 6, 100);
      drive();
      n = 0;
      while (bi[0] < 3 && n < 50) begin cycle(); n++; end
      link_up = 1'b0;
      drain("link_drop", 100);
      chk("linkdrop_fc0", fc(0), 64'd27);
      chk("linkdrop_dc0", dc(0), 64'd0);

      // Randomized traffic with link/drop_en toggling and random tready.
      rnd_link = 1'b1; tr_mode = 2;
      for (int ch = 0; ch < N_CH; ch++) load(ch, 30, 1, 6, 60);
      drive();
      drain("random", 20000);
      rnd_link = 1'b0; link_up = 1'b1; drop_en = 1'b0; tr_mode = 0;
      drive();
      repeat (2) cycle();

      // Reset mid-frame: channel 2 frame leaves rr_ptr at 3, then reset
      // on beat 3 of a 6-beat channel 1 frame.
      load(2, 1, 2, 2, 100);
      drive();
      drain("pre_reset", 100);
      load(1, 1, 6, 6, 100);
      drive();
      n = 0;
      while (bi[1] < 2 && n < 50) begin cycle(); n++; end
      reset = 1'b1;
      #1;
      chk("arst_tready", 64'(s_axis_tready), 64'd0);
      chk("arst_mvalid", 64'(m_axis_tvalid), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      m_st = 0; m_g = 0; m_ptr = 0;
      for (int ch = 0; ch < N_CH; ch++) begin
         m_fc[ch] = 0; m_dc[ch] = 0; bi[ch] = 0; vld[ch] = 1'b0; left[ch] = 0; pop[ch] = 1'b0;
      end
      gq.delete(); prev_busy = 1'b0;
      load(2, 1, 3, 3, 100);
      load(3, 1, 3, 3, 100);
      drive();
      repeat (2) cycle();
      chk("arst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("arst_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("arst_active", 64'(active_ch), 64'd0);
      reset = 1'b0;
      drain("post_reset", 100);
      chk("post_reset_grants", 64'(gq.size()), 64'd2);
      if (gq.size() >= 2) begin
         chk("post_reset_first", 64'(gq[0]), 64'd2);
         chk("post_reset_second", 64'(gq[1]), 64'd3);
      end

      // Saturation: 40 frames on channel 0 with a 5-bit counter.
      load(0, 40, 1, 2, 100);
      drive();
      drain("saturation", 500);
      chk("sat_fc0", fc(0), 64'(CNT_MAX));
      chk("sat_fc2", fc(2), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/niu_tx_arbiter.md
# niu_tx_arbiter

Parametrised N-channel transmit front end for the 10GBASE-R network interface: merges `N_CH` independent AXI-Stream frame sources into the single 64-bit MAC transmit stream with frame-granular round-robin arbitration. Sits between the user logic and the `tx_axis_*` port of the network interface, in the `clk156` domain. Adds behaviour the single-channel interface lacks:
- link-aware drop or hold;
- per-channel frame and drop statistics.

## Interface
- `N_CH`, 4, number of input channels (2..16)
- `DATA_W`, 64, stream data width; `KEEP_W` = `DATA_W`/8
- `CNT_W`, 32, width of each statistics counter
- `clk156`  in  1  156.25 MHz core clock; the only clock
- `reset`  in  1  asynchronous, active-high reset
- `s_axis_tdata`  in  `N_CH*DATA_W`  channel i at [i*DATA_W +: DATA_W]
- `s_axis_tkeep`  in  `N_CH*KEEP_W`  per-channel byte enables
- `s_axis_tvalid` / `s_axis_tlast`  in  `N_CH`  per-channel valid / end of frame
- `s_axis_tready`  out  `N_CH`  per-channel ready
- `m_axis_tdata` / `m_axis_tkeep`  out  `DATA_W` / `KEEP_W`  to MAC
- `m_axis_tvalid` / `m_axis_tlast`  out  1  to MAC
- `m_axis_tready`  in  1  from MAC
- `link_up`  in  1  PCS block lock (`core_status[0]`), synchronous to `clk156`
- `drop_en`  in  1  1 = discard frames while link down; 0 = hold them (backpressure)
- `frame_cnt`  out  `N_CH*CNT_W`  frames forwarded per channel
- `drop_cnt`  out  `N_CH*CNT_W`  frames discarded per channel
- `active_ch`  out  `$clog2(N_CH)`  currently granted channel
- `busy`  out  1  high in FWD or DROP

## Operation
- FSM states: IDLE, FWD, DROP.
- **IDLE**
  - Requests are `s_axis_tvalid`.
  - If there is any request and `link_up`=1: grant the first requesting channel at or after `rr_ptr` (wrapping mod `N_CH`) and go to FWD.
  - If there is any request, `link_up`=0 and `drop_en`=1: grant the same way and go to DROP.
  - If `link_up`=0 and `drop_en`=0: stay in IDLE.
  - All `s_axis_tready`=0 and `m_axis_tvalid`=0 while in IDLE.
- **FWD** (combinational pass-through of the granted channel g)
  - `m_axis_tdata`/`m_axis_tkeep`/`m_axis_tlast`/`m_axis_tvalid` = channel g.
  - `s_axis_tready[g]` = `m_axis_tready`; all other readies are 0.
  - On the beat where `tlast` is accepted (valid & ready & last): `frame_cnt[g]`++, `rr_ptr` = (g+1) mod `N_CH`, go to IDLE.
- **DROP**
  - `s_axis_tready[g]`=1, `m_axis_tvalid`=0.
  - On the beat where `tlast` is accepted: `drop_cnt[g]`++, `rr_ptr` = (g+1) mod `N_CH`, go to IDLE.
- **Link change mid-frame:** ignored. FWD and DROP always run to `tlast`; frames are never truncated or spliced.
- **`drop_en` change:** sampled only in IDLE.
- **Counters:** saturate at all-ones and never wrap; counting is independent per channel.
- **Idle outputs:** while not in FWD, `m_axis_tdata`/`m_axis_tkeep`/`m_axis_tlast` are driven to 0.
- **Reset:** returns the FSM to IDLE and `rr_ptr` to 0, and clears all counters. A frame in progress when reset asserts is abandoned; upstream sources must restart it.

## Timing
- **Reset values:**
  - all `s_axis_tready`=0;
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0;
  - counters 0, `active_ch`=0, `busy`=0.
- **Arbitration latency:** 1 cycle. A request seen in IDLE at cycle t gives the first data transfer possible at t+1.
- **Inter-frame gap:** exactly 1 IDLE cycle after each accepted `tlast`. Back-to-back frames from one channel therefore cost one bubble.
- **In-frame path:** zero-latency, combinational from `s_axis` to `m_axis` within FWD. No data storage.
- **Counter update timing:** counters update on the clock edge that accepts `tlast`; the new value is visible the following cycle.
- **`active_ch`:** registered at grant; holds its value through IDLE until the next grant.
- **AXI rule:** once `m_axis_tvalid` is high, data is held until `m_axis_tready`. This relies on source compliance; the block adds no skid.

## Structure
- Shared package `niu_pkg`:
  - FSM state enum `niu_arb_state_t` {IDLE, FWD, DROP};
  - `NIU_DATA_W`=64, `NIU_KEEP_W`=8 constants;
  - saturating-increment function.
- Sub-module `niu_rr_arbiter`:
  - parametrised `N_CH`;
  - inputs `req` and `rr_ptr`;
  - outputs a one-hot grant, the encoded grant and `any`;
  - purely combinational, two-pass masked priority encoder.
- Top level holds the FSM, grant register, `rr_ptr`, data mux and counters.

## Test plan
- **Round-robin fairness:** `N_CH`=4, all channels continuously offer 3-beat frames, `link_up`=1, `m_axis_tready`=1 → grant order 0,1,2,3,0…; each frame takes 4 cycles (3 data + 1 IDLE); after 100 frames every `frame_cnt`=25.
- **Backpressure:** channel 2 sends an 8-beat frame while `m_axis_tready` toggles 1,0,1,0 → output beats identical to input, order preserved; `s_axis_tready[2]` mirrors `m_axis_tready`; other readies stay 0.
- **Drop mode:** `link_up`=0, `drop_en`=1, channels 1 and 3 each send 2 frames → `m_axis_tvalid` never asserted; `drop_cnt[1]`=2, `drop_cnt[3]`=2, `frame_cnt` all 0.
- **Hold mode and link events:**
  - `link_up`=0, `drop_en`=0 → all readies stay 0 indefinitely;
  - raising `link_up` → forwarding starts 1 cycle later;
  - dropping `link_up` mid-frame → that frame completes intact.
- **Saturation:** `CNT_W`=4, 20 frames on channel 0 → `frame_cnt[0]` holds 15.
- **Async reset mid-frame:** assert `reset` on beat 3 of a 6-beat frame → within the same cycle all readies=0 and `m_axis_tvalid`=0; after release `rr_ptr`=0 and counters=0; the next grant goes to the lowest requesting channel.
